// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexed hex display driver with
// frame-synchronous loads, per-digit blanking and leading-zero suppression.
module seven_seg_mux #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter bit SYNC_FRAME   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  localparam logic [6:0]        SEG_INV = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_INV  = {DIGITS{ACTIVE_LOW}};

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                slot_end;
  logic                wrap;

  logic [4*DIGITS-1:0] disp_nib;
  logic [DIGITS-1:0]   disp_dp;
  logic [DIGITS-1:0]   disp_blank;
  logic [4*DIGITS-1:0] pend_nib;
  logic [DIGITS-1:0]   pend_dp;
  logic [DIGITS-1:0]   pend_blank;
  logic                pend_vld;

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_dark;
  logic                guard;
  logic [DIGITS-1:0]   sup;
  logic [6:0]          seg_n;
  logic                dp_n;
  logic [DIGITS-1:0]   an_n;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  assign slot_end = (cnt == CNT_MAX);
  assign wrap     = slot_end && (idx == IDX_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Display takes the old pending image at wrap before a coincident load
  // refills pending, so the flag ends set in that case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_nib   <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
      pend_nib   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_vld   <= 1'b0;
    end else if (SYNC_FRAME) begin
      if (wrap && pend_vld) begin
        disp_nib   <= pend_nib;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
      end
      if (load) begin
        pend_nib   <= data_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_vld   <= 1'b1;
      end else if (wrap) begin
        pend_vld   <= 1'b0;
      end
    end else if (load) begin
      disp_nib   <= data_in;
      disp_dp    <= dp_in;
      disp_blank <= blank_in;
    end
  end

  // Suppression runs from the top digit down; a set dp stops the run.
  always_comb begin
    logic run;
    sup = '0;
    run = lz_en;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      run    = run && (disp_nib[4*d +: 4] == 4'h0) && !disp_dp[d];
      sup[d] = run;
    end
  end

  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    an_n     = '0;
    guard    = (cnt < BLANK_END);
    for (int d = 0; d < DIGITS; d++) begin
      if (idx == IW'(d)) begin
        cur_nib  = disp_nib[4*d +: 4];
        cur_dp   = disp_dp[d];
        cur_dark = disp_blank[d] | sup[d];
        an_n[d]  = !guard;
      end
    end
    seg_n = (guard || cur_dark) ? 7'h00 : hex7(cur_nib);
    dp_n  = !guard && !cur_dark && cur_dp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_INV;
      dp         <= ACTIVE_LOW;
      an         <= AN_INV;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_n ^ SEG_INV;
      dp         <= dp_n ^ ACTIVE_LOW;
      an         <= an_n ^ AN_INV;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: directed stimulus with a per-cycle scoreboard
// for a 4-digit, 8-cycle-slot, active-low display.
module tb_seven_seg_mux;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_assert = 0;
  int n_fail   = 0;
  int t        = 0;

  always #5 clk = ~clk;

  seven_seg_mux #(
    .DIGITS(4),
    .REFRESH_DIV(8),
    .BLANK_CYCLES(2),
    .ACTIVE_LOW(1'b1),
    .SYNC_FRAME(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .data_in(data_in),
    .dp_in(dp_in),
    .blank_in(blank_in),
    .lz_en(lz_en),
    .seg(seg),
    .dp(dp),
    .an(an),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[n];
  endfunction

  // Reference model indexed by position since reset release
  logic [12:0] sb [$];
  logic [12:0] e;
  int          pos = 0;
  int          slot;
  int          dig;
  logic        m_wrap;
  logic        m_run;
  logic        m_dark;
  logic [3:0]  m_sup;
  logic [15:0] m_nib = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_bl = '0;
  logic [15:0] p_nib = '0;
  logic [3:0]  p_dp = '0;
  logic [3:0]  p_bl = '0;
  logic        p_flag = 1'b0;
  logic [3:0]  x_an;
  logic [6:0]  x_seg;
  logic        x_dp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos = 0;
      m_nib = '0; m_dp = '0; m_bl = '0;
      p_nib = '0; p_dp = '0; p_bl = '0;
      p_flag = 1'b0;
      sb.delete();
    end else begin
      slot   = pos % 8;
      dig    = (pos / 8) % 4;
      m_wrap = (pos % 32) == 31;
      m_run  = lz_en;
      m_sup  = '0;
      for (int d = 3; d >= 1; d--) begin
        m_run    = m_run && (m_nib[d*4 +: 4] == 4'h0) && !m_dp[d];
        m_sup[d] = m_run;
      end
      if (slot < 2) begin
        x_an = 4'hF; x_seg = 7'h7F; x_dp = 1'b1;
      end else begin
        m_dark = m_bl[dig] || m_sup[dig];
        x_an   = ~(4'b0001 << dig);
        x_seg  = m_dark ? 7'h7F : ~hex7(m_nib[dig*4 +: 4]);
        x_dp   = m_dark ? 1'b1 : ~m_dp[dig];
      end
      sb.push_back({x_an, x_seg, x_dp, m_wrap});
      if (m_wrap && p_flag) begin
        m_nib = p_nib; m_dp = p_dp; m_bl = p_bl;
      end
      if (load) begin
        p_nib = data_in; p_dp = dp_in; p_bl = blank_in; p_flag = 1'b1;
      end else if (m_wrap) begin
        p_flag = 1'b0;
      end
      pos++;
    end
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("scan", {3'b0, an, seg, dp, frame_done}, {3'b0, e});
    end
  end

  task automatic to(input int target);
    while (t < target) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic ck(input string tag, input logic [3:0] a,
                    input logic [6:0] s, input logic d);
    chk(tag, {4'b0, an, seg, dp}, {4'b0, a, s, d});
  endtask

  task automatic do_load(input int at, input logic [15:0] v,
                         input logic [3:0] p, input logic [3:0] b);
    to(at - 1);
    load = 1'b1; data_in = v; dp_in = p; blank_in = b;
    to(at);
    load = 1'b0;
  endtask

  initial begin
    load = 1'b0; data_in = '0; dp_in = '0; blank_in = '0; lz_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", {3'b0, an, seg, dp, frame_done},
        {3'b0, 4'hF, 7'h7F, 1'b1, 1'b0});
    rst_n = 1'b1;
    t = 0;

    to(2);  ck("rel_guard", 4'hF, 7'h7F, 1'b1);
    to(3);  ck("rel_d0", 4'hE, 7'h40, 1'b1);
    to(31); chk("fd_c31", {15'b0, frame_done}, 16'd0);
    to(32); chk("fd_c32", {15'b0, frame_done}, 16'd1);
    to(33); chk("fd_c33", {15'b0, frame_done}, 16'd0);

    do_load(34, 16'h12AF, 4'h0, 4'h0);
    to(36); ck("sync_hold", 4'hE, 7'h40, 1'b1);
    to(64); chk("fd_c64", {15'b0, frame_done}, 16'd1);
    to(68); ck("sync_d0", 4'hE, 7'h0E, 1'b1);
    to(76); ck("sync_d1", 4'hD, 7'h08, 1'b1);
    to(84); ck("sync_d2", 4'hB, 7'h24, 1'b1);
    to(92); ck("sync_d3", 4'h7, 7'h79, 1'b1);

    do_load(96, 16'h3456, 4'h0, 4'h0);
    to(100); ck("wrap_ld_hold", 4'hE, 7'h0E, 1'b1);
    to(132); ck("wrap_ld_show", 4'hE, 7'h02, 1'b1);

    do_load(150, 16'hAAAA, 4'h0, 4'h0);
    do_load(160, 16'h0007, 4'h0, 4'h0);
    do_load(192, 16'h0000, 4'h0, 4'h0);
    to(196); ck("last_wins", 4'hE, 7'h78, 1'b1);
    to(228); ck("wrap_pend_next", 4'hE, 7'h40, 1'b1);

    lz_en = 1'b1;
    do_load(230, 16'h0040, 4'h0, 4'h0);
    to(260); ck("lz_d0", 4'hE, 7'h40, 1'b1);
    to(268); ck("lz_d1", 4'hD, 7'h19, 1'b1);
    to(276); ck("lz_d2", 4'hB, 7'h7F, 1'b1);
    to(284); ck("lz_d3", 4'h7, 7'h7F, 1'b1);

    lz_en = 1'b0;
    do_load(290, 16'h1234, 4'b0011, 4'b0010);
    to(324); ck("dp_d0", 4'hE, 7'h19, 1'b0);
    to(332); ck("blank_d1", 4'hD, 7'h7F, 1'b1);

    do_load(340, 16'h8888, 4'h0, 4'h0);
    to(345);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {3'b0, an, seg, dp, frame_done},
           {3'b0, 4'hF, 7'h7F, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    to(4);  ck("post_rst_d0", 4'hE, 7'h40, 1'b1);
    to(12); ck("post_rst_d1", 4'hD, 7'h40, 1'b1);
    to(36); ck("pend_discard", 4'hE, 7'h40, 1'b1);
    to(40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
